mod12_count_checker: RTL and testbench
======================================

MOD12_COUNT_CHECKER -- requirements
Module: mod12_count_checker

Interface
REQ-001 SHALL have parameter: ERR_LIMIT, 4, mismatch count (1..255) that forces FAIL.
REQ-002 SHALL have port: clock  input  1  rising-edge clock.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: load  input  1  load control driven to the observed counter.
REQ-005 SHALL have port: up_down  input  1  direction driven to the observed counter; 0 = up, 1 = down.
REQ-006 SHALL have port: data_in  input  4  load value driven to the observed counter.
REQ-007 SHALL have port: count_in  input  4  registered count returned by the observed counter.
REQ-008 SHALL have port: expected  output  4  model prediction of count_in for the next sample.
REQ-009 SHALL have port: mismatch  output  1  one-cycle pulse; the compared sample differed from the prediction.
REQ-010 SHALL have port: err_count  output  8  saturating mismatch total.
REQ-011 SHALL have port: synced  output  1  high in CHECK and FAIL.
REQ-012 SHALL have port: fail  output  1  high in FAIL.
REQ-013 SHALL have port: wrap_up  output  1  one-cycle pulse on an up-wrap.
REQ-014 SHALL have port: wrap_down  output  1  one-cycle pulse on a down-wrap.

Function
REQ-015 SHALL sample load, up_down, data_in and count_in on every rising clock edge; every output is registered.
REQ-016 SHALL compute next(c) for sampled count c in priority order:
- load=1 -> data_in.
- else up_down=0 -> 0 if c>=12, else c+1.
- else -> 11 if c>=12 or c==0, else c-1.
REQ-017 SHALL implement the states SYNC, CHECK and FAIL.
REQ-018 SYNC SHALL perform no compare; it SHALL load expected with next(count_in) and go to CHECK on the same edge.
REQ-019 CHECK SHALL compare count_in with expected; on a difference it SHALL assert mismatch for exactly one cycle.
REQ-020 CHECK SHALL reload expected with next(count_in) on every edge, so the prediction resynchronises to the actual count after a mismatch.
REQ-021 err_count SHALL increment by 1 per mismatch and hold at 255.
REQ-022 CHECK SHALL go to FAIL on the edge where the incremented err_count equals ERR_LIMIT.
REQ-023 FAIL SHALL hold expected and err_count, keep mismatch, wrap_up and wrap_down at 0, and stay in FAIL until reset.
REQ-024 wrap_up SHALL pulse when, in SYNC or CHECK, the rule c>=12 -> 0 is applied with load=0.
REQ-025 wrap_down SHALL pulse when, in SYNC or CHECK, a down rule yielding 11 is applied with load=0.
REQ-026 A load sample SHALL set neither wrap pulse.
REQ-027 data_in values 12..15 SHALL be legal load values and SHALL be modelled by the same rules.

Reset
REQ-028 With reset high at an edge, the block SHALL enter SYNC and drive expected=0, mismatch=0, err_count=0, synced=0, fail=0, wrap_up=0, wrap_down=0; reset SHALL win over every other input.
REQ-029 Reset asserted in any state, including FAIL, SHALL discard the prediction; the first edge after reset deasserts is a SYNC sample.

Configuration
REQ-030 Macro MOD12_CHK_WRAP_EN SHALL control wrap detection.
- Defined: wrap_up and wrap_down behave per REQ-024 to REQ-026.
- Undefined: both ports remain and are tied to 0, and no wrap logic is generated.
- All other behaviour SHALL be identical in both builds.

Verification
REQ-031 Reset, then up_down=0 and a correct counter for 20 cycles -> sequence 0,1,...,12,0,...; mismatch=0; err_count=0; synced=1 from the 2nd cycle.
REQ-032 In CHECK with expected=5, force count_in=9 -> mismatch pulses once; err_count=1; next expected=10 (up).
REQ-033 ERR_LIMIT=4 with four forced mismatches -> fail=1 after the 4th; later mismatches leave err_count=4.
REQ-034 load=1, data_in=14, then up -> expected 14 then 0 with one wrap_up; down from 0 -> expected 11 with one wrap_down (macro defined); both pulses stay 0 when the macro is undefined.
REQ-035 Assert reset mid-FAIL with err_count=4 -> err_count=0, fail=0, synced=0; next edge synced=1.
REQ-036 load=1 and up_down=1 sampled together with data_in=3 -> expected=3, no wrap pulse.

Source files
------------

// File: rtl/mod12_count_checker.sv
// mod12_count_checker
// Shadow model and checker for a 0..12 up/down counter with parallel load.
// The block samples the counter's control inputs and its returned count on
// every edge and predicts the count for the following sample. A mismatch
// pulses once and bumps a saturating error total. Once the total reaches
// ERR_LIMIT, the checker latches in FAIL until reset.
//
// Build option: define MOD12_CHK_WRAP_EN to generate the wrap_up / wrap_down
// pulse logic. Without it, both ports are present but tied to 0.
module mod12_count_checker #(
  parameter int ERR_LIMIT = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic       up_down,
  input  logic [3:0] data_in,
  input  logic [3:0] count_in,
  output logic [3:0] expected,
  output logic       mismatch,
  output logic [7:0] err_count,
  output logic       synced,
  output logic       fail,
  output logic       wrap_up,
  output logic       wrap_down
);

  localparam logic [1:0] ST_SYNC  = 2'd0;
  localparam logic [1:0] ST_CHECK = 2'd1;
  localparam logic [1:0] ST_FAIL  = 2'd2;

  localparam logic [7:0] ERR_LIMIT_C = ERR_LIMIT[7:0];
  localparam logic [7:0] ERR_MAX     = 8'd255;
  localparam logic [3:0] TOP_COUNT   = 4'd11;
  localparam logic [3:0] WRAP_FLOOR  = 4'd12;

  logic [1:0] state_q, state_d;
  logic [3:0] expected_q, expected_d;
  logic       mismatch_q, mismatch_d;
  logic [7:0] err_count_q, err_count_d;
  logic       synced_q, synced_d;
  logic       fail_q, fail_d;

  logic [3:0] next_count;
  logic       count_hi;
  logic       count_zero;

  // Counter model: what the observed counter should hold after this edge.
  always_comb begin
    count_hi   = (count_in >= WRAP_FLOOR);
    count_zero = (count_in == 4'd0);
    next_count = count_in;
    if (load) begin
      next_count = data_in;
    end else if (!up_down) begin
      next_count = count_hi ? 4'd0 : (count_in + 4'd1);
    end else begin
      next_count = (count_hi || count_zero) ? TOP_COUNT : (count_in - 4'd1);
    end
  end

  // Checker state machine: first sample after reset only seeds the prediction.
  always_comb begin
    state_d     = state_q;
    expected_d  = expected_q;
    mismatch_d  = 1'b0;
    err_count_d = err_count_q;
    case (state_q)
      ST_SYNC: begin
        expected_d = next_count;
        state_d    = ST_CHECK;
      end
      ST_CHECK: begin
        // Always re-seed from the real count so one glitch gives one mismatch.
        expected_d = next_count;
        if (count_in != expected_q) begin
          mismatch_d  = 1'b1;
          err_count_d = (err_count_q == ERR_MAX) ? ERR_MAX : (err_count_q + 8'd1);
          if (err_count_d == ERR_LIMIT_C) begin
            state_d = ST_FAIL;
          end
        end
      end
      ST_FAIL: begin
        // Frozen until reset: prediction and error total are held.
        state_d = ST_FAIL;
      end
      default: begin
        state_d = ST_SYNC;
      end
    endcase
    synced_d = (state_d != ST_SYNC);
    fail_d   = (state_d == ST_FAIL);
  end

  // State and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_SYNC;
      expected_q  <= 4'd0;
      mismatch_q  <= 1'b0;
      err_count_q <= 8'd0;
      synced_q    <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      expected_q  <= expected_d;
      mismatch_q  <= mismatch_d;
      err_count_q <= err_count_d;
      synced_q    <= synced_d;
      fail_q      <= fail_d;
    end
  end

`ifdef MOD12_CHK_WRAP_EN
  logic wrap_up_q, wrap_up_d;
  logic wrap_down_q, wrap_down_d;
  logic model_active;

  // Wrap detection: only counted rules (not loads) while the model is live.
  always_comb begin
    model_active = (state_q == ST_SYNC) || (state_q == ST_CHECK);
    wrap_up_d    = model_active && !load && !up_down && count_hi;
    wrap_down_d  = model_active && !load && up_down && (count_hi || count_zero);
  end

  // Wrap pulse registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      wrap_up_q   <= 1'b0;
      wrap_down_q <= 1'b0;
    end else begin
      wrap_up_q   <= wrap_up_d;
      wrap_down_q <= wrap_down_d;
    end
  end

  assign wrap_up   = wrap_up_q;
  assign wrap_down = wrap_down_q;
`else
  assign wrap_up   = 1'b0;
  assign wrap_down = 1'b0;
`endif

  assign expected  = expected_q;
  assign mismatch  = mismatch_q;
  assign err_count = err_count_q;
  assign synced    = synced_q;
  assign fail      = fail_q;

endmodule

// File: tb/tb_mod12_count_checker.sv
// Directed testbench for mod12_count_checker (ERR_LIMIT = 4).
// Each step compares the packed output vector
// {expected, mismatch, err_count, synced, fail, wrap_up, wrap_down}
// against a hand-computed value.
module tb_mod12_count_checker;

`ifdef MOD12_CHK_WRAP_EN
  localparam logic W = 1'b1;
`else
  localparam logic W = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       load = 1'b0;
  logic       up_down = 1'b0;
  logic [3:0] data_in = 4'd0;
  logic [3:0] count_in = 4'd0;
  logic [3:0] expected;
  logic       mismatch;
  logic [7:0] err_count;
  logic       synced;
  logic       fail;
  logic       wrap_up;
  logic       wrap_down;

  int n_vec = 0;
  int n_bad = 0;

  logic [16:0] obs;
  logic [16:0] req;
  assign obs = {expected, mismatch, err_count, synced, fail, wrap_up, wrap_down};

  // Correct counter trace for the count-up run: 0..12 then wrap to 0.
  logic [3:0] up_seq [0:20] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6,
                               4'd7, 4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd0,
                               4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7};

  mod12_count_checker #(.ERR_LIMIT(4)) dut (
    .clock    (clock),
    .reset    (reset),
    .load     (load),
    .up_down  (up_down),
    .data_in  (data_in),
    .count_in (count_in),
    .expected (expected),
    .mismatch (mismatch),
    .err_count(err_count),
    .synced   (synced),
    .fail     (fail),
    .wrap_up  (wrap_up),
    .wrap_down(wrap_down)
  );

  always #5 clock = ~clock;

  function automatic logic [16:0] pack(input logic [3:0] e, input logic m,
                                       input logic [7:0] ec, input logic s,
                                       input logic f, input logic wu,
                                       input logic wd);
    return {e, m, ec, s, f, wu, wd};
  endfunction

  // Apply one sample and move to 1 time unit after the capturing edge.
  task automatic drive(input logic rst, input logic ld, input logic ud,
                       input logic [3:0] d, input logic [3:0] c);
    reset    = rst;
    load     = ld;
    up_down  = ud;
    data_in  = d;
    count_in = c;
    @(posedge clock);
    #1;
    $display("step rst=%0b ld=%0b ud=%0b d=%0d c=%0d -> exp=%0d mm=%0b err=%0d sync=%0b fail=%0b wu=%0b wd=%0b",
             rst, ld, ud, d, c, expected, mismatch, err_count, synced, fail, wrap_up, wrap_down);
  endtask

  task automatic test_reset();
    // Reset must beat a simultaneous load.
    drive(1'b1, 1'b1, 1'b0, 4'd9, 4'd5);
    req = pack(4'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_vec++;
    if (obs !== req) begin
      n_bad++;
      $display("FAIL reset_load: got %h want %h", obs, req);
    end
    drive(1'b1, 1'b0, 1'b1, 4'd0, 4'd0);
    req = pack(4'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_vec++;
    if (obs !== req) begin
      n_bad++;
      $display("FAIL reset_hold: got %h want %h", obs, req);
    end
  endtask

  task automatic test_count_up();
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 1'b0, 1'b0, 4'd0, up_seq[i]);
      req = pack(up_seq[i+1], 1'b0, 8'd0, 1'b1, 1'b0, W & (up_seq[i] == 4'd12), 1'b0);
      n_vec++;
      if (obs !== req) begin
        n_bad++;
        $display("FAIL count_up[%0d]: got %h want %h", i, obs, req);
      end
    end
  endtask

  task automatic test_mismatch();
    drive(1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
    req = pack(4'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_vec++;
    if (obs !== req) begin
      n_bad++;
      $display("FAIL mm_reset: got %h want %h", obs, req);
    end
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0, 1'b0, 4'd0, 4'(i));
      req = pack(4'(i + 1), 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      n_vec++;
      if (obs !== req) begin
        n_bad++;
        $display("FAIL mm_pre[%0d]: got %h want %h", i, obs, req);
      end
    end
    // expected is 5 here; inject 9.
    drive(1'b0, 1'b0, 1'b0, 4'd0, 4'd9);
    req = pack(4'd10, 1'b1, 8'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    n_vec++;
    if (obs !== req) begin
      n_bad++;
      $display("FAIL mm_pulse: got %h want %h", obs, req);
    end
    drive(1'b0, 1'b0, 1'b0, 4'd0, 4'd10);
    req = pack(4'd11, 1'b0, 8'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    n_vec++;
    if (obs !== req) begin
      n_bad++;
      $display("FAIL mm_resync: got %h want %h", obs, req);
    end
  endtask

  task automatic test_fail();
    // expected=11, err=1: three more mismatches reach the limit of 4.
    drive(1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    req = pack(4'd1, 1'b1, 8'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    n_vec++;
    if (obs !== req) begin
      n_bad++;
      $display("FAIL fail_err2: got %h want %h", obs, req);
    end
    drive(1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    req = pack(4'd1, 1'b1, 8'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    n_vec++;
    if (obs !== req) begin
      n_bad++;
      $display("FAIL fail_err3: got %h want %h", obs, req);
    end
    drive(1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    req = pack(4'd1, 1'b1, 8'd4, 1'b1, 1'b1, 1'b0, 1'b0);
    n_vec++;
    if (obs !== req) begin
      n_bad++;
      $display("FAIL fail_enter: got %h want %h", obs, req);
    end
    drive(1'b0, 1'b0, 1'b0, 4'd0, 4'd7);
    req = pack(4'd1, 1'b0, 8'd4, 1'b1, 1'b1, 1'b0, 1'b0);
    n_vec++;
    if (obs !== req) begin
      n_bad++;
      $display("FAIL fail_hold: got %h want %h", obs, req);
    end
    drive(1'b0, 1'b0, 1'b0, 4'd0, 4'd12);
    req = pack(4'd1, 1'b0, 8'd4, 1'b1, 1'b1, 1'b0, 1'b0);
    n_vec++;
    if (obs !== req) begin
      n_bad++;
      $display("FAIL fail_nowrap: got %h want %h", obs, req);
    end
  endtask

  task automatic test_reset_from_fail();
    drive(1'b1, 1'b0, 1'b0, 4'd0, 4'd5);
    req = pack(4'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_vec++;
    if (obs !== req) begin
      n_bad++;
      $display("FAIL rff_reset: got %h want %h", obs, req);
    end
    drive(1'b0, 1'b0, 1'b0, 4'd0, 4'd3);
    req = pack(4'd4, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    n_vec++;
    if (obs !== req) begin
      n_bad++;
      $display("FAIL rff_sync: got %h want %h", obs, req);
    end
  endtask

  task automatic test_load_wrap();
    drive(1'b0, 1'b1, 1'b0, 4'd14, 4'd4);
    req = pack(4'd14, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    n_vec++;
    if (obs !== req) begin
      n_bad++;
      $display("FAIL lw_load14: got %h want %h", obs, req);
    end
    drive(1'b0, 1'b0, 1'b0, 4'd0, 4'd14);
    req = pack(4'd0, 1'b0, 8'd0, 1'b1, 1'b0, W, 1'b0);
    n_vec++;
    if (obs !== req) begin
      n_bad++;
      $display("FAIL lw_upwrap: got %h want %h", obs, req);
    end
    drive(1'b0, 1'b0, 1'b1, 4'd0, 4'd0);
    req = pack(4'd11, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, W);
    n_vec++;
    if (obs !== req) begin
      n_bad++;
      $display("FAIL lw_dnwrap: got %h want %h", obs, req);
    end
  endtask

  task automatic test_load_down();
    drive(1'b0, 1'b1, 1'b1, 4'd3, 4'd11);
    req = pack(4'd3, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    n_vec++;
    if (obs !== req) begin
      n_bad++;
      $display("FAIL ld_load3: got %h want %h", obs, req);
    end
    drive(1'b0, 1'b0, 1'b1, 4'd0, 4'd3);
    req = pack(4'd2, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    n_vec++;
    if (obs !== req) begin
      n_bad++;
      $display("FAIL ld_down: got %h want %h", obs, req);
    end
    drive(1'b0, 1'b1, 1'b0, 4'd13, 4'd2);
    req = pack(4'd13, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    n_vec++;
    if (obs !== req) begin
      n_bad++;
      $display("FAIL ld_load13: got %h want %h", obs, req);
    end
    drive(1'b0, 1'b0, 1'b1, 4'd0, 4'd13);
    req = pack(4'd11, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, W);
    n_vec++;
    if (obs !== req) begin
      n_bad++;
      $display("FAIL ld_dn13: got %h want %h", obs, req);
    end
    drive(1'b0, 1'b0, 1'b1, 4'd0, 4'd11);
    req = pack(4'd10, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    n_vec++;
    if (obs !== req) begin
      n_bad++;
      $display("FAIL ld_dn11: got %h want %h", obs, req);
    end
  endtask

  task automatic test_back_to_back();
    // expected=10: two consecutive mismatches, then a correct sample.
    drive(1'b0, 1'b0, 1'b0, 4'd0, 4'd5);
    req = pack(4'd6, 1'b1, 8'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    n_vec++;
    if (obs !== req) begin
      n_bad++;
      $display("FAIL b2b_first: got %h want %h", obs, req);
    end
    drive(1'b0, 1'b0, 1'b0, 4'd0, 4'd9);
    req = pack(4'd10, 1'b1, 8'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    n_vec++;
    if (obs !== req) begin
      n_bad++;
      $display("FAIL b2b_second: got %h want %h", obs, req);
    end
    drive(1'b0, 1'b0, 1'b0, 4'd0, 4'd10);
    req = pack(4'd11, 1'b0, 8'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    n_vec++;
    if (obs !== req) begin
      n_bad++;
      $display("FAIL b2b_clear: got %h want %h", obs, req);
    end
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_mismatch();
    test_fail();
    test_reset_from_fail();
    test_load_wrap();
    test_load_down();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
